// File: rtl/memory_pkg.sv
// Shared types and constants for the MIPS memory (M) pipeline stage.
// Holds the access FSM state enum, the byte-lane mask and the timeout counter width.
// Package only: no ports, no logic.
package memory_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Byte 0 (big-endian) is the most significant lane; shift right by lane index.
  localparam logic [3:0] LANE_MASK = 4'b1000;

  // The wait counter never exceeds ACK_TIMEOUT-1, so clog2(ACK_TIMEOUT) bits suffice.
  function automatic int cnt_width(input int ack_timeout);
    return (ack_timeout > 2) ? $clog2(ack_timeout) : 1;
  endfunction

  // X/M pipeline register contents.
  typedef struct packed {
    logic        valid;
    logic        dmwe;
    logic        rwe;
    logic        rdst;
    logic        rwd;
    logic        byte_op;
    logic        ld_unsigned;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] alu_out;
    logic [31:0] rb;
  } xm_t;

  // M/W pipeline register contents.
  typedef struct packed {
    logic        valid;
    logic        rwe;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] data;
  } mw_t;

endpackage

// File: rtl/memory_stage_if.sv
// Bundle of execute-stage inputs, data-memory handshake, hazard/bypass and writeback signals.
// Ports: slave = memory_stage side, master = environment (execute, memory, writeback) side.
// Pure wiring, no latency, no backpressure of its own.
interface memory_stage_if;
  // execute stage -> M
  logic        x_valid;
  logic        x_dmwe;
  logic        x_rwe;
  logic        x_rdst;
  logic        x_rwd;
  logic        x_dm_byte;
  logic        x_ld_unsigned;
  logic [31:0] x_pc;
  logic [31:0] x_insn;
  logic [31:0] x_alu_out;
  logic [31:0] x_rb;
  // hazard / bypass
  logic        m_stall;
  logic [31:0] mx_bypass;
  logic [4:0]  m_dest;
  logic        m_rwe;
  // data memory
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  // writeback
  logic        w_valid;
  logic        w_rwe;
  logic [4:0]  w_dest;
  logic [31:0] w_pc;
  logic [31:0] w_insn;
  logic [31:0] w_data;
  logic        m_bus_err;

  modport slave (
    input  x_valid, x_dmwe, x_rwe, x_rdst, x_rwd, x_dm_byte, x_ld_unsigned,
    input  x_pc, x_insn, x_alu_out, x_rb,
    input  dm_ack, dm_rdata,
    output m_stall, mx_bypass, m_dest, m_rwe,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output w_valid, w_rwe, w_dest, w_pc, w_insn, w_data, m_bus_err
  );

  modport master (
    output x_valid, x_dmwe, x_rwe, x_rdst, x_rwd, x_dm_byte, x_ld_unsigned,
    output x_pc, x_insn, x_alu_out, x_rb,
    output dm_ack, dm_rdata,
    input  m_stall, mx_bypass, m_dest, m_rwe,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  w_valid, w_rwe, w_dest, w_pc, w_insn, w_data, m_bus_err
  );
endinterface

// File: rtl/memory_stage_load_align.sv
// Formats raw big-endian read data into the 32-bit load result (LW/LB/LBU).
// Latency: combinational. No backpressure.
// Ports: rdata_i (raw word), lane_i (addr[1:0]), byte_i (byte load), unsigned_i (zero-extend), data_o.
module load_align (
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic        byte_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0] sel;

  always_comb begin
    sel = 8'h00;
    case (lane_i)
      2'd0:    sel = rdata_i[31:24];
      2'd1:    sel = rdata_i[23:16];
      2'd2:    sel = rdata_i[15:8];
      default: sel = rdata_i[7:0];
    endcase
  end

  always_comb begin
    data_o = rdata_i;
    if (byte_i) begin
      data_o = unsigned_i ? {24'h0, sel} : {{24{sel[7]}}, sel};
    end
  end

endmodule

// File: rtl/memory_stage.sv
// M pipeline stage: X/M register, data-memory handshake with ack timeout, load format, M/W register.
// Latency: one cycle X->W with zero-wait memory; +N cycles for an N-cycle ack, capped by ACK_TIMEOUT.
// Backpressure: m_stall holds upstream while a request waits for dm_ack; timeout abandons the access.
// Ports: clock, reset_n (async, active-low), bus (memory_stage_if.slave).
// Optional: MEMORY_ALIGN_CHECK_EN rejects misaligned word accesses with a bus error pulse.
module memory_stage
  import memory_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic           clock,
  input  logic           reset_n,
  memory_stage_if.slave  bus
);

  localparam int CW = cnt_width(ACK_TIMEOUT);
  // The counter is compared against its pre-increment value, so the access is
  // abandoned in request cycle ACK_TIMEOUT (counter reaching ACK_TIMEOUT-1).
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 2);

  xm_t           m_q, m_d;
  mw_t           w_q, w_d;
  mem_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        mem_op;
  logic        misalign;
  logic        dm_req;
  logic        timeout;
  logic        stall;
  logic        bus_err;
  logic [1:0]  lane;
  logic [31:0] ld_data;

  assign lane   = m_q.alu_out[1:0];
  assign mem_op = m_q.valid & (m_q.dmwe | m_q.rwd);

`ifdef MEMORY_ALIGN_CHECK_EN
  assign misalign = mem_op & ~m_q.byte_op & (lane != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // A rejected misaligned access never reaches memory.
  assign dm_req  = mem_op & ~misalign;
  // Ack in the final cycle wins over timeout.
  assign timeout = (state_q == ST_WAIT) & (cnt_q == CNT_LAST) & ~bus.dm_ack;

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (dm_req && !bus.dm_ack) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.dm_ack || timeout) state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    stall   = dm_req & ~bus.dm_ack & ~timeout;
    bus_err = timeout | misalign;
  end

  load_align u_load_align (
    .rdata_i    (bus.dm_rdata),
    .lane_i     (lane),
    .byte_i     (m_q.byte_op),
    .unsigned_i (m_q.ld_unsigned),
    .data_o     (ld_data)
  );

  // Pipeline register next state: both registers hold together while stalled.
  always_comb begin
    m_d = m_q;
    w_d = w_q;
    if (!stall) begin
      m_d.valid       = bus.x_valid;
      m_d.dmwe        = bus.x_dmwe;
      m_d.rwe         = bus.x_rwe;
      m_d.rdst        = bus.x_rdst;
      m_d.rwd         = bus.x_rwd;
      m_d.byte_op     = bus.x_dm_byte;
      m_d.ld_unsigned = bus.x_ld_unsigned;
      m_d.pc          = bus.x_pc;
      m_d.insn        = bus.x_insn;
      m_d.alu_out     = bus.x_alu_out;
      m_d.rb          = bus.x_rb;

      w_d.valid = m_q.valid;
      // An abandoned or rejected access retires without writing the register file.
      w_d.rwe   = m_q.valid & m_q.rwe & ~bus_err;
      w_d.dest  = bus.m_dest;
      w_d.pc    = m_q.pc;
      w_d.insn  = m_q.insn;
      w_d.data  = m_q.rwd ? ld_data : m_q.alu_out;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_q <= '0;
      w_q <= '0;
    end else begin
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // Hazard / bypass
  assign bus.m_stall   = stall;
  assign bus.mx_bypass = m_q.alu_out;
  assign bus.m_dest    = m_q.rdst ? m_q.insn[15:11] : m_q.insn[20:16];
  assign bus.m_rwe     = m_q.valid & m_q.rwe;
  assign bus.m_bus_err = bus_err;

  // Memory request; everything is zeroed when no request is outstanding.
  assign bus.dm_req  = dm_req;
  assign bus.dm_we   = dm_req & m_q.dmwe;
  assign bus.dm_addr = dm_req ? {m_q.alu_out[31:2], 2'b00} : 32'h0;

  always_comb begin
    bus.dm_be    = 4'b0000;
    bus.dm_wdata = 32'h0;
    if (dm_req) begin
      bus.dm_be = 4'b1111;
      if (m_q.dmwe) begin
        if (m_q.byte_op) begin
          bus.dm_be    = LANE_MASK >> lane;
          bus.dm_wdata = {4{m_q.rb[7:0]}};
        end else begin
          bus.dm_wdata = m_q.rb;
        end
      end
    end
  end

  // Writeback
  assign bus.w_valid = w_q.valid;
  assign bus.w_rwe   = w_q.rwe;
  assign bus.w_dest  = w_q.dest;
  assign bus.w_pc    = w_q.pc;
  assign bus.w_insn  = w_q.insn;
  assign bus.w_data  = w_q.data;

endmodule

// File: tb/tb_memory_stage.sv
// Directed testbench for memory_stage: loads, stores, wait states, timeout, reset, bubbles.
// Clock period 10; inputs driven 1 after the rising edge, outputs sampled on the falling edge.
// ACK_TIMEOUT fixed at 16.
module tb_memory_stage;

  localparam logic [31:0] INSN_RT8  = 32'h0008_0000;  // rt = 8
  localparam logic [31:0] INSN_RD9  = 32'h0000_4800;  // rd = 9
  localparam logic [31:0] INSN_RD10 = 32'h0000_5000;  // rd = 10
  localparam logic [31:0] INSN_RD11 = 32'h0000_5800;  // rd = 11

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_stage_if mif ();

  memory_stage #(.ACK_TIMEOUT(16)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (mif.slave)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] pc_cnt   = 32'h0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, dmwe, rwe, rdst, rwd, bop, uns,
                       input logic [31:0] alu, rb, insn);
    mif.x_valid       = v;
    mif.x_dmwe        = dmwe;
    mif.x_rwe         = rwe;
    mif.x_rdst        = rdst;
    mif.x_rwd         = rwd;
    mif.x_dm_byte     = bop;
    mif.x_ld_unsigned = uns;
    mif.x_alu_out     = alu;
    mif.x_rb          = rb;
    mif.x_insn        = insn;
    mif.x_pc          = pc_cnt;
    pc_cnt            = pc_cnt + 32'd4;
  endtask

  task automatic bubble;
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset;
    mif.dm_ack   = 1'b0;
    mif.dm_rdata = 32'h0;
    // A load presented during reset must not produce a request.
    drive(1, 0, 1, 0, 1, 0, 0, 32'h1234_5678, 32'h0, INSN_RT8);
    repeat (2) @(negedge clk);
    n_checks++; if (mif.dm_req !== 1'b0) begin n_fail++; $display("FAIL reset_dm_req: got %b want 0", mif.dm_req); end
    n_checks++; if (mif.m_stall !== 1'b0) begin n_fail++; $display("FAIL reset_m_stall: got %b want 0", mif.m_stall); end
    n_checks++; if (mif.w_valid !== 1'b0) begin n_fail++; $display("FAIL reset_w_valid: got %b want 0", mif.w_valid); end
    n_checks++; if (mif.w_data !== 32'h0) begin n_fail++; $display("FAIL reset_w_data: got %h want 0", mif.w_data); end
    n_checks++; if (mif.mx_bypass !== 32'h0) begin n_fail++; $display("FAIL reset_mx_bypass: got %h want 0", mif.mx_bypass); end
    n_checks++; if (mif.dm_be !== 4'h0) begin n_fail++; $display("FAIL reset_dm_be: got %b want 0000", mif.dm_be); end
    n_checks++; if (mif.m_bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_m_bus_err: got %b want 0", mif.m_bus_err); end
    bubble();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lb(input logic uns, input logic [31:0] exp);
    tick();
    drive(1, 0, 1, 0, 1, 1, uns, 32'h0000_1002, 32'h0, INSN_RT8);
    mif.dm_ack   = 1'b1;
    mif.dm_rdata = 32'h1122_F344;
    tick();
    bubble();
    @(negedge clk);
    n_checks++; if (mif.m_stall !== 1'b0) begin n_fail++; $display("FAIL lb_stall u=%b: got %b want 0", uns, mif.m_stall); end
    n_checks++; if (mif.dm_req !== 1'b1) begin n_fail++; $display("FAIL lb_dm_req u=%b: got %b want 1", uns, mif.dm_req); end
    n_checks++; if (mif.dm_addr !== 32'h1000) begin n_fail++; $display("FAIL lb_dm_addr u=%b: got %h want 00001000", uns, mif.dm_addr); end
    n_checks++; if (mif.dm_be !== 4'b1111) begin n_fail++; $display("FAIL lb_dm_be u=%b: got %b want 1111", uns, mif.dm_be); end
    n_checks++; if (mif.m_dest !== 5'd8) begin n_fail++; $display("FAIL lb_m_dest u=%b: got %0d want 8", uns, mif.m_dest); end
    tick();
    mif.dm_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (mif.w_data !== exp) begin n_fail++; $display("FAIL lb_w_data u=%b: got %h want %h", uns, mif.w_data, exp); end
    n_checks++; if (mif.w_rwe !== 1'b1) begin n_fail++; $display("FAIL lb_w_rwe u=%b: got %b want 1", uns, mif.w_rwe); end
    n_checks++; if (mif.w_dest !== 5'd8) begin n_fail++; $display("FAIL lb_w_dest u=%b: got %0d want 8", uns, mif.w_dest); end
  endtask

  task automatic test_sb;
    tick();
    drive(1, 1, 0, 0, 0, 1, 0, 32'h0000_2001, 32'hABCD_00EE, 32'h0);
    mif.dm_ack = 1'b1;
    tick();
    bubble();
    @(negedge clk);
    n_checks++; if (mif.dm_be !== 4'b0100) begin n_fail++; $display("FAIL sb_dm_be: got %b want 0100", mif.dm_be); end
    n_checks++; if (mif.dm_wdata !== 32'hEEEE_EEEE) begin n_fail++; $display("FAIL sb_dm_wdata: got %h want eeeeeeee", mif.dm_wdata); end
    n_checks++; if (mif.dm_addr !== 32'h2000) begin n_fail++; $display("FAIL sb_dm_addr: got %h want 00002000", mif.dm_addr); end
    n_checks++; if (mif.dm_we !== 1'b1) begin n_fail++; $display("FAIL sb_dm_we: got %b want 1", mif.dm_we); end
    tick();
    mif.dm_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (mif.w_valid !== 1'b1) begin n_fail++; $display("FAIL sb_w_valid: got %b want 1", mif.w_valid); end
    n_checks++; if (mif.w_rwe !== 1'b0) begin n_fail++; $display("FAIL sb_w_rwe: got %b want 0", mif.w_rwe); end
  endtask

  task automatic test_lw_wait;
    int stalls;
    stalls = 0;
    tick();
    drive(1, 0, 1, 0, 1, 0, 0, 32'h0000_3004, 32'h0, INSN_RT8);
    mif.dm_ack   = 1'b0;
    mif.dm_rdata = 32'hDEAD_BEEF;
    tick();
    drive(1, 0, 1, 1, 0, 0, 0, 32'h0000_0055, 32'h0, INSN_RD9);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mif.m_stall === 1'b1) stalls++;
      n_checks++; if (mif.dm_addr !== 32'h3004) begin n_fail++; $display("FAIL lw_addr_stable c=%0d: got %h want 00003004", c, mif.dm_addr); end
      tick();
    end
    mif.dm_ack = 1'b1;
    @(negedge clk);
    n_checks++; if (stalls !== 3) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d want 3", stalls); end
    n_checks++; if (mif.m_stall !== 1'b0) begin n_fail++; $display("FAIL lw_stall_on_ack: got %b want 0", mif.m_stall); end
    n_checks++; if (mif.mx_bypass !== 32'h3004) begin n_fail++; $display("FAIL lw_bypass_held: got %h want 00003004", mif.mx_bypass); end
    tick();
    mif.dm_ack = 1'b0;
    bubble();
    @(negedge clk);
    n_checks++; if (mif.w_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_w_data: got %h want deadbeef", mif.w_data); end
    n_checks++; if (mif.w_rwe !== 1'b1) begin n_fail++; $display("FAIL lw_w_rwe: got %b want 1", mif.w_rwe); end
    n_checks++; if (mif.m_dest !== 5'd9) begin n_fail++; $display("FAIL lw_next_m_dest: got %0d want 9", mif.m_dest); end
    n_checks++; if (mif.mx_bypass !== 32'h55) begin n_fail++; $display("FAIL lw_next_bypass: got %h want 00000055", mif.mx_bypass); end
  endtask

  // ack_at = 0: memory never answers; otherwise ack in that request cycle.
  task automatic test_timeout(input int ack_at);
    int err_cyc;
    int end_cyc;
    bit done;
    err_cyc = 0;
    end_cyc = 0;
    done    = 1'b0;
    tick();
    drive(1, 0, 1, 0, 1, 0, 0, 32'h0000_4000, 32'h0, INSN_RT8);
    mif.dm_ack   = 1'b0;
    mif.dm_rdata = 32'hCAFE_F00D;
    tick();
    drive(1, 0, 1, 1, 0, 0, 0, 32'h0000_0077, 32'h0, INSN_RD10);
    for (int c = 1; c <= 24 && !done; c++) begin
      if (c == ack_at) mif.dm_ack = 1'b1;
      @(negedge clk);
      if (mif.m_bus_err === 1'b1 && err_cyc == 0) err_cyc = c;
      if (mif.m_stall === 1'b0) begin
        end_cyc = c;
        done    = 1'b1;
      end else begin
        tick();
      end
    end
    if (ack_at == 0) begin
      n_checks++; if (err_cyc !== 16) begin n_fail++; $display("FAIL to_err_cycle: got %0d want 16", err_cyc); end
      n_checks++; if (end_cyc !== 16) begin n_fail++; $display("FAIL to_release_cycle: got %0d want 16", end_cyc); end
    end else begin
      n_checks++; if (err_cyc !== 0) begin n_fail++; $display("FAIL ackto_err_cycle: got %0d want 0", err_cyc); end
      n_checks++; if (end_cyc !== ack_at) begin n_fail++; $display("FAIL ackto_release_cycle: got %0d want %0d", end_cyc, ack_at); end
    end
    tick();
    mif.dm_ack = 1'b0;
    bubble();
    @(negedge clk);
    n_checks++; if (mif.w_valid !== 1'b1) begin n_fail++; $display("FAIL to_w_valid ack_at=%0d: got %b want 1", ack_at, mif.w_valid); end
    n_checks++; if (mif.w_rwe !== (ack_at != 0)) begin n_fail++; $display("FAIL to_w_rwe ack_at=%0d: got %b want %b", ack_at, mif.w_rwe, ack_at != 0); end
    n_checks++; if (mif.m_dest !== 5'd10) begin n_fail++; $display("FAIL to_next_m_dest ack_at=%0d: got %0d want 10", ack_at, mif.m_dest); end
    n_checks++; if (mif.m_bus_err !== 1'b0) begin n_fail++; $display("FAIL to_err_one_cycle ack_at=%0d: got %b want 0", ack_at, mif.m_bus_err); end
    if (ack_at != 0) begin
      n_checks++; if (mif.w_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL ackto_w_data: got %h want cafef00d", mif.w_data); end
    end
  endtask

  task automatic test_bubble;
    tick();
    drive(0, 1, 1, 0, 1, 0, 0, 32'h0000_7000, 32'h0, INSN_RT8);
    mif.dm_ack = 1'b1;  // stray ack with no request
    tick();
    bubble();
    @(negedge clk);
    n_checks++; if (mif.dm_req !== 1'b0) begin n_fail++; $display("FAIL bub_dm_req: got %b want 0", mif.dm_req); end
    n_checks++; if (mif.m_rwe !== 1'b0) begin n_fail++; $display("FAIL bub_m_rwe: got %b want 0", mif.m_rwe); end
    tick();
    mif.dm_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (mif.w_valid !== 1'b0) begin n_fail++; $display("FAIL bub_w_valid: got %b want 0", mif.w_valid); end
  endtask

  task automatic test_align;
    tick();
    drive(1, 0, 1, 0, 1, 0, 0, 32'h0000_1001, 32'h0, INSN_RT8);
`ifdef MEMORY_ALIGN_CHECK_EN
    mif.dm_ack = 1'b0;
    tick();
    bubble();
    @(negedge clk);
    n_checks++; if (mif.dm_req !== 1'b0) begin n_fail++; $display("FAIL align_dm_req: got %b want 0", mif.dm_req); end
    n_checks++; if (mif.m_bus_err !== 1'b1) begin n_fail++; $display("FAIL align_bus_err: got %b want 1", mif.m_bus_err); end
    n_checks++; if (mif.m_stall !== 1'b0) begin n_fail++; $display("FAIL align_stall: got %b want 0", mif.m_stall); end
    tick();
    @(negedge clk);
    n_checks++; if (mif.w_rwe !== 1'b0) begin n_fail++; $display("FAIL align_w_rwe: got %b want 0", mif.w_rwe); end
    n_checks++; if (mif.m_bus_err !== 1'b0) begin n_fail++; $display("FAIL align_err_one_cycle: got %b want 0", mif.m_bus_err); end
`else
    mif.dm_ack   = 1'b1;
    mif.dm_rdata = 32'h1234_5678;
    tick();
    bubble();
    @(negedge clk);
    n_checks++; if (mif.dm_addr !== 32'h1000) begin n_fail++; $display("FAIL noalign_addr: got %h want 00001000", mif.dm_addr); end
    n_checks++; if (mif.m_bus_err !== 1'b0) begin n_fail++; $display("FAIL noalign_bus_err: got %b want 0", mif.m_bus_err); end
    tick();
    mif.dm_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (mif.w_data !== 32'h1234_5678) begin n_fail++; $display("FAIL noalign_w_data: got %h want 12345678", mif.w_data); end
    n_checks++; if (mif.w_rwe !== 1'b1) begin n_fail++; $display("FAIL noalign_w_rwe: got %b want 1", mif.w_rwe); end
`endif
  endtask

  task automatic test_reset_mid;
    tick();
    drive(1, 0, 1, 0, 1, 0, 0, 32'h0000_6000, 32'h0, INSN_RT8);
    mif.dm_ack = 1'b0;
    tick();
    bubble();
    repeat (3) tick();
    @(negedge clk);
    n_checks++; if (mif.m_stall !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall: got %b want 1", mif.m_stall); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (mif.dm_req !== 1'b0) begin n_fail++; $display("FAIL rst_async_dm_req: got %b want 0", mif.dm_req); end
    n_checks++; if (mif.m_stall !== 1'b0) begin n_fail++; $display("FAIL rst_async_stall: got %b want 0", mif.m_stall); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(1, 0, 1, 1, 0, 0, 0, 32'h0000_0007, 32'h0, INSN_RD11);
    tick();
    bubble();
    @(negedge clk);
    n_checks++; if (mif.m_stall !== 1'b0) begin n_fail++; $display("FAIL rst_add_stall: got %b want 0", mif.m_stall); end
    tick();
    @(negedge clk);
    n_checks++; if (mif.w_data !== 32'h7) begin n_fail++; $display("FAIL rst_add_w_data: got %h want 00000007", mif.w_data); end
    n_checks++; if (mif.w_dest !== 5'd11) begin n_fail++; $display("FAIL rst_add_w_dest: got %0d want 11", mif.w_dest); end
    n_checks++; if (mif.w_rwe !== 1'b1) begin n_fail++; $display("FAIL rst_add_w_rwe: got %b want 1", mif.w_rwe); end
  endtask

  initial begin
    test_reset();
    test_lb(1'b0, 32'hFFFF_FFF3);
    test_lb(1'b1, 32'h0000_00F3);
    test_sb();
    test_lw_wait();
    test_timeout(0);
    test_timeout(16);
    test_bubble();
    test_align();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline M stage of the MIPS core, directly downstream of the execute stage. It owns the X/M pipeline register, drives the data-memory handshake for LW/LB/LBU/SW/SB with variable ack latency and a bounded timeout, formats load data, and presents the registered M/W result to writeback. It also supplies the MX bypass value and the hazard-unit destination info, and stalls upstream while an access is outstanding.

## Interface
- ACK_TIMEOUT, 16: cycles in WAIT without `dm_ack` before the access is abandoned (range 2..255).
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- x_valid, x_dmwe, x_rwe, x_rdst, x_rwd, x_dm_byte, x_ld_unsigned  in  1 each  execute-stage instruction controls; `x_rwd`=1 selects load data for writeback
- x_pc, x_insn, x_alu_out, x_rb  in  32 each  execute results; `x_alu_out` is the effective address for memory ops
- m_stall  out  1  hold execute/decode/fetch this cycle
- mx_bypass  out  32  registered M-stage ALU result
- m_dest  out  5  M-stage destination register
- m_rwe  out  1  M-stage register write, qualified by valid
- dm_req, dm_we  out  1 each  memory request, write strobe
- dm_addr, dm_wdata  out  32 each  word-aligned address, store data
- dm_be  out  4  byte enables
- dm_ack  in  1  access complete; `dm_rdata` is valid in the same cycle
- dm_rdata  in  32  read data
- w_valid, w_rwe  out  1 each  writeback valid, register write
- w_dest  out  5  writeback destination
- w_pc, w_insn, w_data  out  32 each  writeback payload
- m_bus_err  out  1  one-cycle pulse on timeout

## Operation
- mem_op = m_valid & (m_dmwe | m_rwd). Destination: `m_rdst` ? insn[15:11] : insn[20:16]. `m_rwe` = m_valid & rwe.
- Byte order is big-endian. Lane k = addr[1:0]. Byte 0 is bits [31:24].
- `dm_addr` = {addr[31:2], 2'b00}.
- Word store: `dm_be` = 4'b1111, `dm_wdata` = rb.
- Byte store: `dm_be` = 4'b1000 >> k, `dm_wdata` = {4{rb[7:0]}}.
- Loads: `dm_be` = 4'b1111. The selected byte is sign- or zero-extended per `ld_unsigned`.
- FSM has two states, IDLE and WAIT.
  - `dm_req` = mem_op and not yet retired.
  - IDLE → WAIT when `dm_req` is high and `dm_ack` is low; the counter is cleared.
  - WAIT increments the counter each cycle.
  - WAIT → IDLE on `dm_ack`, or when the counter reaches ACK_TIMEOUT−1. On timeout: `m_bus_err` pulses, the instruction retires with `w_rwe`=0, and no write is performed.
- `m_stall` = `dm_req` & ~`dm_ack` & ~timeout.
- X/M register loads `x_*` on every edge where `m_stall`=0. While stalled it holds.
- M/W register loads on every edge where `m_stall`=0. `w_data` = `rwd` ? formatted load : alu_out. `w_valid` = m_valid.
- `mx_bypass` is the M register's alu_out, independent of stall.

## Timing
- Reset: every output and register is 0 and the FSM is IDLE, including mid-access. `dm_req` drops immediately (asynchronously).
- Zero-wait memory (`dm_ack` high in the first request cycle): no stall. The instruction reaches W one cycle after entering M.
- N-cycle ack: `m_stall` is high for N cycles. `dm_req` and `dm_addr` are stable throughout.
- `dm_ack` arriving in the same cycle as timeout: ack wins, with normal retirement and no `m_bus_err`.
- Non-memory instructions never stall. A bubble (x_valid=0) propagates as w_valid=0.
- `dm_ack` while `dm_req` is low is ignored.

## Configuration
- MEMORY_ALIGN_CHECK_EN defined: a word access with addr[1:0]≠0 issues no `dm_req`, retires without stall with `w_rwe`=0, and pulses `m_bus_err`.
- Not defined: low address bits are silently dropped for word accesses.

## Structure
- `memory_pkg` holds:
  - the FSM state enum
  - the lane-mask constant 4'b1000
  - the counter width derived from ACK_TIMEOUT.
- One sub-module, `load_align`: a combinational function of dm_rdata, lane, byte, and unsigned, producing the 32-bit formatted load.

## Test plan
- LB: addr 0x1002, rdata 0x1122F344, signed → w_data 0xFFFFFFF3. LBU with the same inputs → 0x000000F3.
- SB: addr 0x2001, rb 0xABCD00EE → dm_be 4'b0100, dm_wdata 0xEEEEEEEE, dm_addr 0x2000, dm_we 1.
- LW with ack after 3 cycles → m_stall high 3 cycles, dm_addr stable, then w_data = rdata and w_rwe=1.
- No ack with ACK_TIMEOUT=16 → m_bus_err pulses in request cycle 16, w_rwe=0, and the next instruction advances.
- reset_n low mid-WAIT → dm_req and m_stall fall immediately. After release, an ADD with alu_out 7 flows through to w_data 7 with no stall.
- MEMORY_ALIGN_CHECK_EN with LW at 0x1001 → no dm_req, m_bus_err for 1 cycle, w_rwe=0.
